// File: rtl/math_calculator_fsm.sv
// rtl/math_calculator_fsm.sv - keypad four-function fixed-point calculator with seven-segment output
//
// Purpose: decodes one key code per cycle and runs an entry/operator/result
// FSM with left-to-right operator chaining. Values are signed 16-bit in
// hundredths (5.25 = 525). The five segment outputs show |result| as
// sign, tens, units, tenths, hundredths, active-low {g,f,e,d,c,b,a}.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   button[9:0]       key code (0 = idle)
//   clear, equal      key decodes
//   button_num[3:0]   decoded digit (0 when no digit key)
//   button_op[2:0]    decoded operator: 0 none, 1 add, 2 sub, 3 mul, 4 div
//   num_check[15:0]   operand being entered
//   result_temp[15:0] running accumulator
//   result[15:0]      result latched by the equal key
//   sign/tens/units/tenths/hundredths[6:0]  segment patterns for result
module math_calculator_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  button,
    output logic        clear,
    output logic        equal,
    output logic [3:0]  button_num,
    output logic [2:0]  button_op,
    output logic [15:0] num_check,
    output logic [15:0] result_temp,
    output logic [15:0] result,
    output logic [6:0]  sign,
    output logic [6:0]  tens,
    output logic [6:0]  units,
    output logic [6:0]  tenths,
    output logic [6:0]  hundredths
);

    typedef enum logic [1:0] {S_NUM1, S_OP, S_NUM2, S_RESULT} state_t;

    state_t      state_q, state_d;
    logic [15:0] num_check_q, num_check_d;
    logic [15:0] result_temp_q, result_temp_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        is_digit;
    logic [15:0] digit16;
    logic [15:0] weight;
    logic [15:0] append_val;
    logic [15:0] calc_val;
    logic [15:0] mag;

    // Applies the pending operator with a 32-bit signed intermediate;
    // division truncates toward zero and a zero divisor gives zero.
    function automatic logic [15:0] do_calc(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        logic signed [31:0] a32, b32, r32;
        a32 = {{16{a[15]}}, a};
        b32 = {{16{b[15]}}, b};
        case (op)
            3'd1:    r32 = a32 + b32;
            3'd2:    r32 = a32 - b32;
            3'd3:    r32 = (a32 * b32) / 32'sd100;
            3'd4:    r32 = (b32 == 32'sd0) ? 32'sd0 : (a32 * 32'sd100) / b32;
            default: r32 = a32;
        endcase
        return r32[15:0];
    endfunction

    function automatic logic [6:0] seg_of(input logic [15:0] d);
        case (d)
            16'd0:   seg_of = 7'b1000000;
            16'd1:   seg_of = 7'b1111001;
            16'd2:   seg_of = 7'b0100100;
            16'd3:   seg_of = 7'b0110000;
            16'd4:   seg_of = 7'b0011001;
            16'd5:   seg_of = 7'b0010010;
            16'd6:   seg_of = 7'b0000010;
            16'd7:   seg_of = 7'b1111000;
            16'd8:   seg_of = 7'b0000000;
            16'd9:   seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        clear      = 1'b0;
        equal      = 1'b0;
        button_num = 4'd0;
        button_op  = 3'd0;
        is_digit   = 1'b0;
        case (button)
            10'b00_0000_0001: begin is_digit = 1'b1; button_num = 4'd0; end
            10'b00_0000_0010: begin is_digit = 1'b1; button_num = 4'd1; end
            10'b00_0000_0100: begin is_digit = 1'b1; button_num = 4'd2; end
            10'b00_0000_1000: begin is_digit = 1'b1; button_num = 4'd3; end
            10'b00_0001_0000: begin is_digit = 1'b1; button_num = 4'd4; end
            10'b00_0010_0000: begin is_digit = 1'b1; button_num = 4'd5; end
            10'b00_0100_0000: begin is_digit = 1'b1; button_num = 4'd6; end
            10'b00_1000_0000: begin is_digit = 1'b1; button_num = 4'd7; end
            10'b01_0000_0000: begin is_digit = 1'b1; button_num = 4'd8; end
            10'b10_0000_0000: begin is_digit = 1'b1; button_num = 4'd9; end
            10'b10_0000_0001: button_op = 3'd1;
            10'b10_0000_0010: button_op = 3'd2;
            10'b10_0000_0100: button_op = 3'd3;
            10'b10_0000_1000: button_op = 3'd4;
            10'b11_0000_0000: equal = 1'b1;
            10'b11_1000_0000: clear = 1'b1;
            default: ;
        endcase
    end

    // The digit counter selects the place value of the next digit.
    always_comb begin
        digit16 = {12'd0, button_num};
        case (cnt_q)
            2'd0:    weight = 16'd100;
            2'd1:    weight = 16'd10;
            default: weight = 16'd1;
        endcase
        append_val = num_check_q + digit16 * weight;
        calc_val   = do_calc(op_q, result_temp_q, num_check_q);
    end

    always_comb begin
        state_d       = state_q;
        num_check_d   = num_check_q;
        result_temp_d = result_temp_q;
        result_d      = result_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        if (clear) begin
            state_d       = S_NUM1;
            num_check_d   = 16'd0;
            result_temp_d = 16'd0;
            result_d      = 16'd0;
            op_d          = 3'd0;
            cnt_d         = 2'd0;
        end else if (is_digit) begin
            case (state_q)
                S_NUM1, S_NUM2, S_OP: begin
                    if (cnt_q != 2'd3) begin
                        num_check_d = append_val;
                        cnt_d       = cnt_q + 2'd1;
                    end
                    if (state_q == S_OP) state_d = S_NUM2;
                end
                default: begin
                    // New calculation: result stays on display until the next equal.
                    result_temp_d = 16'd0;
                    num_check_d   = digit16 * 16'd100;
                    cnt_d         = 2'd1;
                    state_d       = S_NUM1;
                end
            endcase
        end else if (button_op != 3'd0) begin
            case (state_q)
                S_NUM1:   result_temp_d = num_check_q;
                S_NUM2:   result_temp_d = calc_val;
                S_RESULT: result_temp_d = result_q;
                default:  ;
            endcase
            op_d        = button_op;
            num_check_d = 16'd0;
            cnt_d       = 2'd0;
            state_d     = S_OP;
        end else if (equal) begin
            case (state_q)
                S_NUM1: begin
                    result_d      = num_check_q;
                    result_temp_d = num_check_q;
                    state_d       = S_RESULT;
                end
                S_NUM2: begin
                    result_d      = calc_val;
                    result_temp_d = calc_val;
                    num_check_d   = 16'd0;
                    cnt_d         = 2'd0;
                    state_d       = S_RESULT;
                end
                S_OP: begin
                    result_d = result_temp_q;
                    state_d  = S_RESULT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_NUM1;
            num_check_q   <= 16'd0;
            result_temp_q <= 16'd0;
            result_q      <= 16'd0;
            op_q          <= 3'd0;
            cnt_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            num_check_q   <= num_check_d;
            result_temp_q <= result_temp_d;
            result_q      <= result_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        mag        = result_q[15] ? (~result_q + 16'd1) : result_q;
        sign       = result_q[15] ? 7'b0111111 : 7'b1111111;
        tens       = seg_of((mag / 16'd1000) % 16'd10);
        units      = seg_of((mag / 16'd100) % 16'd10);
        tenths     = seg_of((mag / 16'd10) % 16'd10);
        hundredths = seg_of(mag % 16'd10);
    end

    assign num_check   = num_check_q;
    assign result_temp = result_temp_q;
    assign result      = result_q;

endmodule

// File: tb/tb_math_calculator_fsm.sv
// tb/tb_math_calculator_fsm.sv - self-checking bench for math_calculator_fsm
module tb_math_calculator_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  button;
    logic        clear, equal;
    logic [3:0]  button_num;
    logic [2:0]  button_op;
    logic [15:0] num_check, result_temp, result;
    logic [6:0]  sign, tens, units, tenths, hundredths;

    math_calculator_fsm dut (
        .clk(clk), .rst(rst), .button(button),
        .clear(clear), .equal(equal), .button_num(button_num), .button_op(button_op),
        .num_check(num_check), .result_temp(result_temp), .result(result),
        .sign(sign), .tens(tens), .units(units), .tenths(tenths), .hundredths(hundredths)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] K_ADD = 10'h201, K_SUB = 10'h202, K_MUL = 10'h204,
                           K_DIV = 10'h208, K_EQ = 10'h300, K_CLR = 10'h380;
    localparam logic [6:0] SEG_TABLE [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_pass   = 0;
    logic check_en = 1'b0;

    // Model: calculator as a user would describe it.
    // m_mode: 0 typing first number, 1 just pressed operator, 2 typing next number, 3 showing answer
    logic [15:0] m_num = 16'd0, m_acc = 16'd0, m_res = 16'd0;
    int m_cnt = 0, m_mode = 0, m_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [9:0] key(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        if (d == 9) k = 10'h200;
        return k;
    endfunction

    function automatic void decode(input logic [9:0] b, output int d, output int op,
                                   output bit eq, output bit clr);
        d = -1; op = 0; eq = (b == K_EQ); clr = (b == K_CLR);
        for (int i = 0; i <= 9; i++) if (b == key(i)) d = i;
        if (b == K_ADD) op = 1;
        if (b == K_SUB) op = 2;
        if (b == K_MUL) op = 3;
        if (b == K_DIV) op = 4;
    endfunction

    function automatic logic [15:0] calc(input int op, input logic [15:0] a, input logic [15:0] b);
        longint x, y, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            1: r = x + y;
            2: r = x - y;
            3: r = (x * y) / 100;
            4: r = (y == 0) ? 0 : (x * 100) / y;
            default: r = x;
        endcase
        return r[15:0];
    endfunction

    task automatic model_step(input logic r, input logic [9:0] b);
        int d, op; bit eq, clr;
        logic [15:0] n, a, s;
        int c, md, p;
        n = m_num; a = m_acc; s = m_res; c = m_cnt; md = m_mode; p = m_pend;
        decode(b, d, op, eq, clr);
        if (r || clr) begin
            n = 0; a = 0; s = 0; c = 0; md = 0; p = 0;
        end else if (d >= 0) begin
            if (md == 3) begin a = 0; n = 0; c = 0; md = 0; end
            if (md == 1) md = 2;
            if (c < 3) begin
                n = n + 16'(d * (c == 0 ? 100 : (c == 1 ? 10 : 1)));
                c++;
            end
        end else if (op != 0) begin
            if (md == 0) a = n;
            else if (md == 2) a = calc(p, a, n);
            else if (md == 3) a = s;
            p = op; n = 0; c = 0; md = 1;
        end else if (eq) begin
            if (md == 0) begin s = n; a = n; md = 3; end
            else if (md == 2) begin a = calc(p, a, n); s = a; n = 0; c = 0; md = 3; end
            else if (md == 1) begin s = a; md = 3; end
        end
        m_num <= n; m_acc <= a; m_res <= s; m_cnt <= c; m_mode <= md; m_pend <= p;
    endtask

    always @(posedge clk) model_step(rst, button);

    always @(negedge clk) begin
        if (check_en) begin
            int d, op, mag; bit eq, clr;
            decode(button, d, op, eq, clr);
            chk("clear", 32'(clear), 32'(clr));
            chk("equal", 32'(equal), 32'(eq));
            chk("button_num", 32'(button_num), (d < 0) ? 32'd0 : 32'(d));
            chk("button_op", 32'(button_op), 32'(op));
            chk("num_check", 32'(num_check), 32'(m_num));
            chk("result_temp", 32'(result_temp), 32'(m_acc));
            chk("result", 32'(result), 32'(m_res));
            mag = int'($signed(m_res));
            if (mag < 0) mag = -mag;
            chk("sign", 32'(sign), ($signed(m_res) < 0) ? 32'h3F : 32'h7F);
            chk("tens", 32'(tens), 32'(SEG_TABLE[(mag / 1000) % 10]));
            chk("units", 32'(units), 32'(SEG_TABLE[(mag / 100) % 10]));
            chk("tenths", 32'(tenths), 32'(SEG_TABLE[(mag / 10) % 10]));
            chk("hundredths", 32'(hundredths), 32'(SEG_TABLE[mag % 10]));
        end
    end

    task automatic press(input logic [9:0] code);
        button = code;
        @(posedge clk);
        #1;
        button = 10'd0;
    endtask

    task automatic digits(input int a, input int b, input int c);
        press(key(a)); press(key(b)); press(key(c));
    endtask

    initial begin
        rst = 1'b1;
        button = 10'd0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("reset result", 32'(result), 32'd0);
        chk("reset num_check", 32'(num_check), 32'd0);
        chk("reset tens", 32'(tens), 32'h40);
        chk("reset sign", 32'(sign), 32'h7F);
        rst = 1'b0;

        // 5.25 + 3 = 8.25
        digits(5, 2, 5);
        chk("entry 525", 32'(num_check), 32'd525);
        press(K_ADD);
        chk("acc 525", 32'(result_temp), 32'd525);
        press(key(3)); press(K_EQ);
        chk("sum 825", 32'(result), 32'd825);
        chk("825 sign", 32'(sign), 32'h7F);
        chk("825 tens", 32'(tens), 32'h40);
        chk("825 units", 32'(units), 32'h00);
        chk("825 tenths", 32'(tenths), 32'h24);
        chk("825 hundredths", 32'(hundredths), 32'h12);

        // chaining: 5 - 3 + 2 = 4
        press(K_CLR);
        digits(5, 0, 0); press(K_SUB); press(key(3)); press(K_ADD);
        chk("chain acc 200", 32'(result_temp), 32'd200);
        press(key(2)); press(K_EQ);
        chk("chain 400", 32'(result), 32'd400);

        // new entry from RESULT, then continue from RESULT with an operator
        press(key(6));
        chk("restart acc 0", 32'(result_temp), 32'd0);
        chk("restart num 600", 32'(num_check), 32'd600);
        chk("result held", 32'(result), 32'd400);
        press(key(0)); press(key(0)); press(K_DIV); press(key(3)); press(K_EQ);
        chk("div 200", 32'(result), 32'd200);
        press(K_MUL); press(key(8)); press(K_EQ);
        chk("mul 1600", 32'(result), 32'd1600);
        chk("1600 tens", 32'(tens), 32'h79);
        chk("1600 units", 32'(units), 32'h02);

        // negative result: 3 - 5 = -2
        press(K_CLR);
        press(key(3)); press(K_SUB); press(key(5)); press(K_EQ);
        chk("neg -200", 32'(result), 32'hFF38);
        chk("neg sign", 32'(sign), 32'h3F);
        chk("neg units", 32'(units), 32'h24);

        // negative division truncates toward zero: -3 / 7 = -0.42
        press(K_CLR);
        press(key(1)); press(K_SUB); press(key(4)); press(K_EQ);
        press(K_DIV); press(key(7)); press(K_EQ);
        chk("neg div -42", 32'(result), 32'hFFD6);

        // divide by zero
        press(K_CLR);
        press(key(4)); press(K_DIV); press(key(0)); press(K_EQ);
        chk("div0", 32'(result), 32'd0);

        // fourth digit ignored; same key twice is two presses
        press(K_CLR);
        digits(1, 2, 3); press(key(4));
        chk("four digits 123", 32'(num_check), 32'd123);
        press(K_CLR);
        press(key(1)); press(key(1));
        chk("repeat key 110", 32'(num_check), 32'd110);

        // two operators in a row: last wins (2 * 3)
        press(K_CLR);
        press(key(2)); press(K_ADD); press(K_MUL); press(key(3)); press(K_EQ);
        chk("last op 600", 32'(result), 32'd600);

        // rst in the middle of the second operand
        press(K_CLR);
        press(key(1)); press(K_ADD); press(key(2));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst num", 32'(num_check), 32'd0);
        chk("rst acc", 32'(result_temp), 32'd0);
        press(key(7));
        chk("rst then 700", 32'(num_check), 32'd700);

        // clear key in the same situation
        press(K_CLR);
        press(key(1)); press(K_ADD); press(key(2)); press(K_CLR);
        chk("clr acc", 32'(result_temp), 32'd0);
        press(key(7)); press(K_EQ);
        chk("clr then 700", 32'(result), 32'd700);

        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/math_calculator_fsm.md
# math_calculator_fsm

Keypad-driven four-function decimal fixed-point calculator. It decodes a 10-bit one-cycle-per-press key code and runs an entry/operator/result FSM with left-to-right operator chaining. It drives five active-low seven-segment digit patterns (sign, tens, units, tenths, hundredths) for the board display, and exposes its internal registers for debug.

## Interface
- No parameters.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `button`  in  10  — key code, one valid code per cycle. Idle is 0.
- `clear`  out  1  — decode: button == 10'b11_1000_0000.
- `equal`  out  1  — decode: button == 10'b11_0000_0000.
- `button_num`  out  4  — decoded digit value 0–9; 0 when no digit is pressed.
- `button_op`  out  3  — decoded operator: 0 none, 1 add, 2 sub, 3 mul, 4 div.
- `num_check`  out  16  — operand currently being entered, signed, in hundredths.
- `result_temp`  out  16  — running accumulator, signed, in hundredths.
- `result`  out  16  — final result after `=`, signed, in hundredths.
- `sign`, `tens`, `units`, `tenths`, `hundredths`  out  7 each  — segment patterns for `result`.

## Operation
- **Key codes:**
  - Digits 0–8 are one-hot on bits 0–8 with bit9 = 0.
  - Digit 9 = 10'b10_0000_0000.
  - Operators: 10'b10_0000_0001 add, _0010 sub, _0100 mul, _1000 div.
  - Equal and clear are as listed in the Interface.
  - Any other nonzero code is ignored; decode outputs for it are 0.
- **Number format:** 16-bit two's complement, value × 100. Example: 5.25 = 525. Arithmetic wraps modulo 2^16.
- **Operand entry:**
  - 1st digit sets the units place, 2nd the tenths, 3rd the hundredths: `num_check` = u·100 + t·10 + h.
  - A 2-bit digit counter tracks position; 4th and later digits are ignored.
  - Example: key 3 alone gives 300.
- **Operations:**
  - add/sub: a ± b.
  - mul: (a·b)/100, 32-bit signed intermediate, truncated toward zero.
  - div: (a·100)/b, 32-bit signed intermediate, truncated toward zero.
  - Division by zero yields 0.
- **FSM states:** NUM1 (entering first operand), OP (operator latched, no digits yet), NUM2 (entering next operand), RESULT.
- **Transitions:**
  - NUM1 + digit → append to `num_check`, stay in NUM1.
  - NUM1 + op → `result_temp` = `num_check`; latch op; clear `num_check` and the digit counter; go to OP.
  - OP + op → replace the pending op; stay in OP.
  - OP + digit → append; go to NUM2.
  - NUM2 + digit → append.
  - NUM2 + op → `result_temp` = `result_temp` (pending op) `num_check`; latch new op; clear `num_check`; go to OP.
  - NUM2 + equal → `result` and `result_temp` both = `result_temp` (pending op) `num_check`; clear `num_check`; go to RESULT.
  - NUM1 + equal → `result` = `result_temp` = `num_check`; go to RESULT.
  - OP + equal → `result` = `result_temp`; go to RESULT.
  - RESULT + op → `result_temp` = `result`; latch op; go to OP.
  - RESULT + digit → clear `result_temp`; start new operand with this digit; go to NUM1. `result` is held until the next equal.
  - RESULT + equal → no change.
- **Clear** (any state) and **rst:** all registers 0, pending op = none, digit counter 0, state NUM1. `rst` has priority over `button`.
- **Display:**
  - Shows |`result`|: tens = (|r|/1000)%10, units = (|r|/100)%10, tenths = (|r|/10)%10, hundredths = |r|%10.
  - The leading zero on tens is shown, not blanked.
  - `sign` = 7'b0111111 ("−") when `result` < 0, else 7'b1111111 (blank).
  - Segment order is {g,f,e,d,c,b,a}, active-low:
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
    - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

## Timing
- Every cycle in which `button` holds a valid code counts as one key press. There is no edge detection or debounce, so the same code on two consecutive cycles is two presses.
- `clear`, `equal`, `button_num`, `button_op` are combinational from `button` (same cycle).
- `num_check`, `result_temp`, `result` and the state register update on the rising edge that samples the key. They are visible one cycle after the press.
- Segment outputs are combinational from the `result` register.
- Reset values: all 16-bit outputs 0; segments show "0000" with sign blank (tens/units/tenths/hundredths = 7'b1000000, `sign` = 7'b1111111).

## Test plan
- rst, then keys 5,2,5,add,3,equal → `num_check` 525 before add; `result_temp` 525 after add; `result` 825; display blank/0/8/2/5.
- clear, then 5,0,0,sub,3,add,2,equal → `result_temp` 200 after add; `result` 400.
- From RESULT with no clear: 6,0,0,div,3,equal → `result` 200; then mul,8,equal → `result` 1600, tens=1, units=6.
- 3,sub,5,equal → `result` = −200 (16'hFF38); `sign` = 7'b0111111; display −02.00.
- 4,div,0,equal → `result` 0. Keys 1,2,3,4 → `num_check` 123 (4th digit ignored). Two ops in a row → last op used.
- Assert `rst` mid-entry (state NUM2) → next cycle all registers 0, state NUM1; clear key gives identical behaviour.
